// File: rtl/reorder_buffer_pkg.sv
// Shared widths, constants, entry layout and tag/pointer helpers for the reorder buffer.
// Optional operand-query ports are enabled with `define ROB_QUERY_EN.
package reorder_buffer_pkg;

  localparam int DEPTH    = 16;
  localparam int TAG_W    = 5;
  localparam int PTR_W    = 4;
  localparam int DATALEN  = 32;
  localparam int REGINDEX = 5;

  localparam logic [TAG_W-1:0]   ROBNOTRENAME = 5'd0;
  localparam logic               TRUE         = 1'b1;
  localparam logic               FALSE        = 1'b0;
  localparam logic [DATALEN-1:0] NULL32       = 32'h0000_0000;

  typedef struct packed {
    logic                busy;
    logic                ready;
    logic                have_rd;
    logic                is_branch;
    logic                mispredict;
    logic [REGINDEX-1:0] rd_index;
    logic [DATALEN-1:0]  value;
    logic [DATALEN-1:0]  target;
  } rob_entry_t;

  // Tags are slot+1 so that tag 0 can mean "not renamed".
  function automatic logic [TAG_W-1:0] ptr_to_tag(input logic [PTR_W-1:0] p);
    return TAG_W'(p) + TAG_W'(1);
  endfunction

  function automatic logic [PTR_W-1:0] tag_slot(input logic [TAG_W-1:0] tag);
    return PTR_W'(tag - TAG_W'(1));
  endfunction

  function automatic logic tag_in_range(input logic [TAG_W-1:0] tag);
    return (tag != ROBNOTRENAME) && (tag <= TAG_W'(DEPTH));
  endfunction

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? PTR_W'(0) : p + PTR_W'(1);
  endfunction

endpackage

// File: rtl/reorder_buffer_rob_ptr_ctrl.sv
// Head/tail/occupancy bookkeeping for the reorder buffer, including wrap and flush.
module rob_ptr_ctrl
  import reorder_buffer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             alloc_i,
  input  logic             commit_i,
  input  logic             flush_i,
  output logic [PTR_W-1:0] head_o,
  output logic [PTR_W-1:0] tail_o,
  output logic             full_o
);

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [TAG_W-1:0] count_q, count_d;

  // Next-state pointers; flush has priority over any same-cycle alloc/commit.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (rdy && flush_i) begin
      head_d  = PTR_W'(0);
      tail_d  = PTR_W'(0);
      count_d = TAG_W'(0);
    end else if (rdy) begin
      if (alloc_i) begin
        tail_d = next_ptr(tail_q);
      end else begin
        tail_d = tail_q;
      end
      if (commit_i) begin
        head_d = next_ptr(head_q);
      end else begin
        head_d = head_q;
      end
      case ({alloc_i, commit_i})
        2'b10:   count_d = count_q + TAG_W'(1);
        2'b01:   count_d = count_q - TAG_W'(1);
        default: count_d = count_q;
      endcase
    end else begin
      count_d = count_q;
    end
  end

  // Pointer state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= PTR_W'(0);
      tail_q  <= PTR_W'(0);
      count_q <= TAG_W'(0);
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head_o = head_q;
  assign tail_o = tail_q;
  assign full_o = (count_q == TAG_W'(DEPTH));

endmodule

// File: rtl/reorder_buffer.sv
// Circular in-order retirement buffer: allocates rename tags, captures CDB results,
// retires one completed entry per cycle and flushes on a mispredicted branch (ROB_QUERY_EN adds operand lookup).
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                alloc_valid,
  input  logic [REGINDEX-1:0] alloc_rd_index,
  input  logic                alloc_have_rd,
  input  logic                alloc_is_branch,
  output logic [TAG_W-1:0]    alloc_tag,
  output logic                rob_full,
  input  logic                cdb_valid,
  input  logic [TAG_W-1:0]    cdb_tag,
  input  logic [DATALEN-1:0]  cdb_value,
  input  logic                cdb_mispredict,
  input  logic [DATALEN-1:0]  cdb_target,
`ifdef ROB_QUERY_EN
  input  logic [TAG_W-1:0]    q1_tag,
  input  logic [TAG_W-1:0]    q2_tag,
  output logic                q1_ready,
  output logic                q2_ready,
  output logic [DATALEN-1:0]  q1_value,
  output logic [DATALEN-1:0]  q2_value,
`endif
  output logic                rob_enable,
  output logic [REGINDEX-1:0] rob_commit_index,
  output logic [TAG_W-1:0]    rob_commit_rename,
  output logic [DATALEN-1:0]  rob_commit_value,
  output logic                jump_wrong,
  output logic [DATALEN-1:0]  jump_target
);

  rob_entry_t entries_q [DEPTH];
  rob_entry_t entries_d [DEPTH];

  logic [PTR_W-1:0]    head_s, tail_s;
  logic                full_s;
  rob_entry_t          head_entry_s;
  logic                flush_fire_s, alloc_fire_s, commit_fire_s, cdb_hit_s;
  logic [PTR_W-1:0]    cdb_slot_s;

  logic                rob_enable_q, rob_enable_d;
  logic [REGINDEX-1:0] commit_index_q, commit_index_d;
  logic [TAG_W-1:0]    commit_rename_q, commit_rename_d;
  logic [DATALEN-1:0]  commit_value_q, commit_value_d;
  logic                jump_wrong_q, jump_wrong_d;
  logic [DATALEN-1:0]  jump_target_q, jump_target_d;

  rob_ptr_ctrl u_ptr (
    .clk      (clk),
    .rst      (rst),
    .rdy      (rdy),
    .alloc_i  (alloc_fire_s),
    .commit_i (commit_fire_s),
    .flush_i  (jump_wrong_q),
    .head_o   (head_s),
    .tail_o   (tail_s),
    .full_o   (full_s)
  );

  // The cycle jump_wrong is high is spent flushing; nothing else is accepted.
  assign head_entry_s  = entries_q[head_s];
  assign cdb_slot_s    = tag_slot(cdb_tag);
  assign flush_fire_s  = rdy && jump_wrong_q;
  assign alloc_fire_s  = rdy && alloc_valid && !full_s && !jump_wrong_q;
  assign commit_fire_s = rdy && !jump_wrong_q && head_entry_s.busy && head_entry_s.ready;
  assign cdb_hit_s     = rdy && !jump_wrong_q && cdb_valid && tag_in_range(cdb_tag)
                         && entries_q[cdb_slot_s].busy;

  // Entry storage next state: completion, then retirement clear, then allocation.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entries_d[i] = entries_q[i];
    end
    if (flush_fire_s) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_d[i] = '0;
      end
    end else begin
      if (cdb_hit_s) begin
        entries_d[cdb_slot_s].ready      = TRUE;
        entries_d[cdb_slot_s].value      = cdb_value;
        entries_d[cdb_slot_s].mispredict = cdb_mispredict;
        entries_d[cdb_slot_s].target     = cdb_target;
      end
      if (commit_fire_s) begin
        entries_d[head_s] = '0;
      end
      if (alloc_fire_s) begin
        entries_d[tail_s].busy       = TRUE;
        entries_d[tail_s].ready      = FALSE;
        entries_d[tail_s].have_rd    = alloc_have_rd;
        entries_d[tail_s].is_branch  = alloc_is_branch;
        entries_d[tail_s].mispredict = FALSE;
        entries_d[tail_s].rd_index   = alloc_rd_index;
        entries_d[tail_s].value      = NULL32;
        entries_d[tail_s].target     = NULL32;
      end
    end
  end

  // Entry storage registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= entries_d[i];
      end
    end
  end

  // Commit/redirect outputs: one-cycle pulses, payload held between commits.
  always_comb begin
    rob_enable_d    = rob_enable_q;
    commit_index_d  = commit_index_q;
    commit_rename_d = commit_rename_q;
    commit_value_d  = commit_value_q;
    jump_wrong_d    = jump_wrong_q;
    jump_target_d   = jump_target_q;
    if (rdy) begin
      if (flush_fire_s) begin
        rob_enable_d = FALSE;
        jump_wrong_d = FALSE;
      end else if (commit_fire_s) begin
        rob_enable_d    = head_entry_s.have_rd;
        commit_index_d  = head_entry_s.rd_index;
        commit_rename_d = ptr_to_tag(head_s);
        commit_value_d  = head_entry_s.value;
        jump_wrong_d    = head_entry_s.is_branch && head_entry_s.mispredict;
        if (head_entry_s.is_branch && head_entry_s.mispredict) begin
          jump_target_d = head_entry_s.target;
        end else begin
          jump_target_d = jump_target_q;
        end
      end else begin
        rob_enable_d = FALSE;
        jump_wrong_d = FALSE;
      end
    end else begin
      rob_enable_d = rob_enable_q;
    end
  end

  // Commit/redirect output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rob_enable_q    <= FALSE;
      commit_index_q  <= REGINDEX'(0);
      commit_rename_q <= ROBNOTRENAME;
      commit_value_q  <= NULL32;
      jump_wrong_q    <= FALSE;
      jump_target_q   <= NULL32;
    end else begin
      rob_enable_q    <= rob_enable_d;
      commit_index_q  <= commit_index_d;
      commit_rename_q <= commit_rename_d;
      commit_value_q  <= commit_value_d;
      jump_wrong_q    <= jump_wrong_d;
      jump_target_q   <= jump_target_d;
    end
  end

  assign alloc_tag         = ptr_to_tag(tail_s);
  assign rob_full          = full_s;
  assign rob_enable        = rob_enable_q;
  assign rob_commit_index  = commit_index_q;
  assign rob_commit_rename = commit_rename_q;
  assign rob_commit_value  = commit_value_q;
  assign jump_wrong        = jump_wrong_q;
  assign jump_target       = jump_target_q;

`ifdef ROB_QUERY_EN
  // A stored result wins; otherwise forward a result broadcast this very cycle.
  function automatic logic [DATALEN:0] query_lookup(
    input logic [TAG_W-1:0]   qtag,
    input rob_entry_t         ent,
    input logic               cv,
    input logic [TAG_W-1:0]   ctag,
    input logic [DATALEN-1:0] cval
  );
    if (tag_in_range(qtag) && ent.busy && ent.ready) begin
      return {TRUE, ent.value};
    end else if (cv && (qtag != ROBNOTRENAME) && (qtag == ctag)) begin
      return {TRUE, cval};
    end else begin
      return {FALSE, NULL32};
    end
  endfunction

  assign {q1_ready, q1_value} = query_lookup(q1_tag, entries_q[tag_slot(q1_tag)],
                                             cdb_valid, cdb_tag, cdb_value);
  assign {q2_ready, q2_value} = query_lookup(q2_tag, entries_q[tag_slot(q2_tag)],
                                             cdb_valid, cdb_tag, cdb_value);
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed scenarios plus random traffic
// against an in-order queue model of the buffer.
module tb_reorder_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        alloc_valid;
  logic [4:0]  alloc_rd_index;
  logic        alloc_have_rd;
  logic        alloc_is_branch;
  logic [4:0]  alloc_tag;
  logic        rob_full;
  logic        cdb_valid;
  logic [4:0]  cdb_tag;
  logic [31:0] cdb_value;
  logic        cdb_mispredict;
  logic [31:0] cdb_target;
  logic        rob_enable;
  logic [4:0]  rob_commit_index;
  logic [4:0]  rob_commit_rename;
  logic [31:0] rob_commit_value;
  logic        jump_wrong;
  logic [31:0] jump_target;
`ifdef ROB_QUERY_EN
  logic [4:0]  q1_tag = 5'd0;
  logic [4:0]  q2_tag = 5'd0;
  logic        q1_ready, q2_ready;
  logic [31:0] q1_value, q2_value;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [4:0]  tag;
    logic [4:0]  rd;
    logic        have_rd;
    logic        is_branch;
    logic        ready;
    logic        mis;
    logic [31:0] val;
    logic [31:0] tgt;
  } m_ent_t;

  m_ent_t      mq[$];
  int          m_next_tag;
  logic        m_en;
  logic [4:0]  m_idx;
  logic [4:0]  m_ren;
  logic [31:0] m_val;
  logic        m_jw;
  logic [31:0] m_jt;

  reorder_buffer dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .alloc_valid(alloc_valid), .alloc_rd_index(alloc_rd_index),
    .alloc_have_rd(alloc_have_rd), .alloc_is_branch(alloc_is_branch),
    .alloc_tag(alloc_tag), .rob_full(rob_full),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .cdb_mispredict(cdb_mispredict), .cdb_target(cdb_target),
`ifdef ROB_QUERY_EN
    .q1_tag(q1_tag), .q2_tag(q2_tag), .q1_ready(q1_ready), .q2_ready(q2_ready),
    .q1_value(q1_value), .q2_value(q2_value),
`endif
    .rob_enable(rob_enable), .rob_commit_index(rob_commit_index),
    .rob_commit_rename(rob_commit_rename), .rob_commit_value(rob_commit_value),
    .jump_wrong(jump_wrong), .jump_target(jump_target)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    mq.delete();
    m_next_tag = 1;
    m_en = 1'b0; m_idx = 5'd0; m_ren = 5'd0; m_val = 32'd0;
    m_jw = 1'b0; m_jt = 32'd0;
  endtask

  task automatic apply_reset();
    rst = 1'b0; rdy = 1'b1;
    alloc_valid = 1'b0; alloc_rd_index = 5'd0; alloc_have_rd = 1'b0; alloc_is_branch = 1'b0;
    cdb_valid = 1'b0; cdb_tag = 5'd0; cdb_value = 32'd0; cdb_mispredict = 1'b0; cdb_target = 32'd0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

`ifdef ROB_QUERY_EN
  function automatic logic [32:0] q_expect(input logic [4:0] t);
    foreach (mq[i]) if (mq[i].tag == t && mq[i].ready) return {1'b1, mq[i].val};
    if (cdb_valid && t != 5'd0 && cdb_tag == t) return {1'b1, cdb_value};
    return {1'b0, 32'd0};
  endfunction
`endif

  // One clock of stimulus; called at a falling edge, returns at the next one.
  task automatic cycle(input logic av, input logic [4:0] rd, input logic hrd, input logic br,
                       input logic cv, input logic [4:0] ct, input logic [31:0] cval,
                       input logic cmis, input logic [31:0] ctgt);
    m_ent_t h;
    bit do_commit, was_full;
`ifdef ROB_QUERY_EN
    logic [32:0] qe;
`endif
    alloc_valid = av; alloc_rd_index = rd; alloc_have_rd = hrd; alloc_is_branch = br;
    cdb_valid = cv; cdb_tag = ct; cdb_value = cval; cdb_mispredict = cmis; cdb_target = ctgt;
    #1;
    n_cmp++;
    if (alloc_tag !== 5'(m_next_tag)) begin
      n_bad++; $display("FAIL alloc_tag got %0d exp %0d at %0t", alloc_tag, m_next_tag, $time);
    end
    n_cmp++;
    if (rob_full !== (mq.size() == 16)) begin
      n_bad++; $display("FAIL rob_full got %0b exp %0b at %0t", rob_full, mq.size() == 16, $time);
    end
`ifdef ROB_QUERY_EN
    qe = q_expect(q1_tag);
    n_cmp++;
    if (q1_ready !== qe[32] || (qe[32] && q1_value !== qe[31:0])) begin
      n_bad++; $display("FAIL q1 got %0b/%h exp %0b/%h at %0t", q1_ready, q1_value, qe[32], qe[31:0], $time);
    end
    qe = q_expect(q2_tag);
    n_cmp++;
    if (q2_ready !== qe[32] || (qe[32] && q2_value !== qe[31:0])) begin
      n_bad++; $display("FAIL q2 got %0b/%h exp %0b/%h at %0t", q2_ready, q2_value, qe[32], qe[31:0], $time);
    end
`endif
    @(posedge clk);
    if (rdy) begin
      if (m_jw) begin
        mq.delete(); m_next_tag = 1; m_en = 1'b0; m_jw = 1'b0;
      end else begin
        was_full  = (mq.size() == 16);
        do_commit = (mq.size() > 0) && mq[0].ready;
        if (do_commit) h = mq[0];
        if (cv) begin
          foreach (mq[i]) if (mq[i].tag == ct) begin
            mq[i].ready = 1'b1; mq[i].val = cval; mq[i].mis = cmis; mq[i].tgt = ctgt;
          end
        end
        if (do_commit) begin
          void'(mq.pop_front());
          m_en = h.have_rd; m_idx = h.rd; m_ren = h.tag; m_val = h.val;
          m_jw = h.is_branch && h.mis;
          if (m_jw) m_jt = h.tgt;
        end else begin
          m_en = 1'b0; m_jw = 1'b0;
        end
        if (av && !was_full) begin
          mq.push_back('{tag: 5'(m_next_tag), rd: rd, have_rd: hrd, is_branch: br,
                         ready: 1'b0, mis: 1'b0, val: 32'd0, tgt: 32'd0});
          m_next_tag = (m_next_tag == 16) ? 1 : m_next_tag + 1;
        end
      end
    end
    #1;
    n_cmp++;
    if (rob_enable !== m_en) begin
      n_bad++; $display("FAIL rob_enable got %0b exp %0b at %0t", rob_enable, m_en, $time);
    end
    n_cmp++;
    if (rob_commit_index !== m_idx || rob_commit_rename !== m_ren || rob_commit_value !== m_val) begin
      n_bad++; $display("FAIL commit got idx %0d ren %0d val %h exp idx %0d ren %0d val %h at %0t",
                        rob_commit_index, rob_commit_rename, rob_commit_value, m_idx, m_ren, m_val, $time);
    end
    n_cmp++;
    if (jump_wrong !== m_jw || jump_target !== m_jt) begin
      n_bad++; $display("FAIL jump got %0b/%h exp %0b/%h at %0t", jump_wrong, jump_target, m_jw, m_jt, $time);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic alloc1(input logic [4:0] rd, input logic hrd, input logic br);
    cycle(1, rd, hrd, br, 0, 0, 0, 0, 0);
  endtask

  task automatic cdb1(input logic [4:0] t, input logic [31:0] v, input logic mis, input logic [31:0] tg);
    cycle(0, 0, 0, 0, 1, t, v, mis, tg);
  endtask

  task automatic test_reset();
    apply_reset();
    rst = 1'b0;
    #1;
    n_cmp++;
    if (rob_enable !== 1'b0 || rob_commit_index !== 5'd0 || rob_commit_rename !== 5'd0 ||
        rob_commit_value !== 32'd0 || jump_wrong !== 1'b0 || jump_target !== 32'd0) begin
      n_bad++; $display("FAIL reset_outputs got en %0b ren %0d val %h jw %0b exp all zero",
                        rob_enable, rob_commit_rename, rob_commit_value, jump_wrong);
    end
    n_cmp++;
    if (alloc_tag !== 5'd1 || rob_full !== 1'b0) begin
      n_bad++; $display("FAIL reset_tag got %0d/%0b exp 1/0", alloc_tag, rob_full);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_in_order();
    apply_reset();
    alloc1(5'd5, 1, 0); alloc1(5'd6, 1, 0); alloc1(5'd7, 1, 0);
    cdb1(5'd3, 32'h30, 0, 0);
    cdb1(5'd1, 32'h10, 0, 0);
    cdb1(5'd2, 32'h20, 0, 0);
    n_cmp++;
    if (rob_enable !== 1'b1 || rob_commit_rename !== 5'd1 || rob_commit_value !== 32'h10 || rob_commit_index !== 5'd5) begin
      n_bad++; $display("FAIL in_order_1 got %0b/%0d/%h exp 1/1/10", rob_enable, rob_commit_rename, rob_commit_value);
    end
    idle(1);
    n_cmp++;
    if (rob_enable !== 1'b1 || rob_commit_rename !== 5'd2 || rob_commit_value !== 32'h20) begin
      n_bad++; $display("FAIL in_order_2 got %0b/%0d/%h exp 1/2/20", rob_enable, rob_commit_rename, rob_commit_value);
    end
    idle(1);
    n_cmp++;
    if (rob_enable !== 1'b1 || rob_commit_rename !== 5'd3 || rob_commit_value !== 32'h30) begin
      n_bad++; $display("FAIL in_order_3 got %0b/%0d/%h exp 1/3/30", rob_enable, rob_commit_rename, rob_commit_value);
    end
    idle(1);
    n_cmp++;
    if (rob_enable !== 1'b0) begin
      n_bad++; $display("FAIL in_order_pulse got %0b exp 0", rob_enable);
    end
  endtask

  task automatic test_full_wrap();
    apply_reset();
    for (int i = 0; i < 16; i++) alloc1(5'(i), 1, 0);
    n_cmp++;
    if (rob_full !== 1'b1 || alloc_tag !== 5'd1) begin
      n_bad++; $display("FAIL full_set got %0b/%0d exp 1/1", rob_full, alloc_tag);
    end
    alloc1(5'd20, 1, 0);
    cdb1(5'd1, 32'hABCD, 0, 0);
    alloc1(5'd21, 1, 0);
    n_cmp++;
    if (rob_enable !== 1'b1 || rob_commit_rename !== 5'd1 || rob_full !== 1'b0 || alloc_tag !== 5'd1) begin
      n_bad++; $display("FAIL full_commit got en %0b ren %0d full %0b tag %0d exp 1/1/0/1",
                        rob_enable, rob_commit_rename, rob_full, alloc_tag);
    end
    alloc1(5'd22, 1, 0);
    n_cmp++;
    if (rob_full !== 1'b1 || alloc_tag !== 5'd2) begin
      n_bad++; $display("FAIL full_wrap got %0b/%0d exp 1/2", rob_full, alloc_tag);
    end
  endtask

  task automatic test_mispredict();
    apply_reset();
    alloc1(5'd3, 1, 0); alloc1(5'd1, 1, 1); alloc1(5'd4, 1, 0);
    cdb1(5'd1, 32'hAA, 0, 0);
    cdb1(5'd2, 32'h44, 1, 32'h1000);
    idle(1);
    n_cmp++;
    if (jump_wrong !== 1'b1 || jump_target !== 32'h1000 || rob_enable !== 1'b1 || rob_commit_value !== 32'h44) begin
      n_bad++; $display("FAIL mispredict_pulse got jw %0b tgt %h en %0b val %h exp 1/1000/1/44",
                        jump_wrong, jump_target, rob_enable, rob_commit_value);
    end
    alloc1(5'd9, 1, 0);
    n_cmp++;
    if (jump_wrong !== 1'b0 || alloc_tag !== 5'd1 || rob_full !== 1'b0) begin
      n_bad++; $display("FAIL flush got jw %0b tag %0d exp 0/1", jump_wrong, alloc_tag);
    end
    cdb1(5'd3, 32'h77, 0, 0);
    idle(2);
    n_cmp++;
    if (rob_enable !== 1'b0 || rob_commit_rename !== 5'd2) begin
      n_bad++; $display("FAIL stale_cdb got en %0b ren %0d exp 0/2", rob_enable, rob_commit_rename);
    end
  endtask

  task automatic test_store_and_ignored();
    apply_reset();
    alloc1(5'd8, 0, 0);
    cdb1(5'd1, 32'h99, 0, 0);
    idle(1);
    n_cmp++;
    if (rob_enable !== 1'b0 || rob_commit_rename !== 5'd1 || alloc_tag !== 5'd2) begin
      n_bad++; $display("FAIL store got en %0b ren %0d tag %0d exp 0/1/2", rob_enable, rob_commit_rename, alloc_tag);
    end
    alloc1(5'd0, 1, 0);
    cdb1(5'd0, 32'h11, 0, 0);
    cdb1(5'd9, 32'h12, 0, 0);
    idle(2);
    n_cmp++;
    if (rob_enable !== 1'b0 || rob_commit_rename !== 5'd1 || alloc_tag !== 5'd3) begin
      n_bad++; $display("FAIL ignored_cdb got en %0b ren %0d tag %0d exp 0/1/3", rob_enable, rob_commit_rename, alloc_tag);
    end
    cdb1(5'd2, 32'h13, 0, 0);
    idle(1);
    n_cmp++;
    if (rob_enable !== 1'b1 || rob_commit_index !== 5'd0 || rob_commit_value !== 32'h13) begin
      n_bad++; $display("FAIL rd0_commit got en %0b idx %0d val %h exp 1/0/13", rob_enable, rob_commit_index, rob_commit_value);
    end
  endtask

  task automatic test_rdy_low();
    apply_reset();
    alloc1(5'd2, 1, 0);
    rdy = 1'b0;
    cdb1(5'd1, 32'h5A, 0, 0);
    alloc1(5'd3, 1, 0);
    idle(1);
    n_cmp++;
    if (alloc_tag !== 5'd2 || rob_enable !== 1'b0) begin
      n_bad++; $display("FAIL rdy_hold got tag %0d en %0b exp 2/0", alloc_tag, rob_enable);
    end
    rdy = 1'b1;
    cdb1(5'd1, 32'h5B, 0, 0);
    rdy = 1'b0;
    idle(2);
    n_cmp++;
    if (rob_enable !== 1'b0 || rob_commit_value !== 32'h0) begin
      n_bad++; $display("FAIL rdy_nocommit got en %0b val %h exp 0/0", rob_enable, rob_commit_value);
    end
    rdy = 1'b1;
    idle(1);
    n_cmp++;
    if (rob_enable !== 1'b1 || rob_commit_value !== 32'h5B) begin
      n_bad++; $display("FAIL rdy_resume got en %0b val %h exp 1/5b", rob_enable, rob_commit_value);
    end
  endtask

  task automatic test_random(input int n);
    logic av, br, hrd, cv, cmis;
    logic [4:0] ct;
    int cand[$];
    apply_reset();
    for (int k = 0; k < n; k++) begin
      rdy = ($urandom_range(0, 9) != 0);
      av  = ($urandom_range(0, 9) < 6);
      br  = ($urandom_range(0, 3) == 0);
      hrd = ($urandom_range(0, 4) != 0);
      cv = 1'b0; ct = 5'd0;
      cand.delete();
      foreach (mq[i]) if (!mq[i].ready) cand.push_back(i);
      if ($urandom_range(0, 9) < 6 && cand.size() > 0) begin
        cv = 1'b1; ct = mq[cand[$urandom_range(0, cand.size() - 1)]].tag;
      end else if ($urandom_range(0, 3) == 0) begin
        cv = 1'b1; ct = 5'($urandom_range(0, 16));
      end
      cmis = ($urandom_range(0, 5) == 0);
`ifdef ROB_QUERY_EN
      q1_tag = 5'($urandom_range(0, 16));
      q2_tag = cv ? ct : 5'($urandom_range(0, 16));
`endif
      cycle(av, 5'($urandom_range(0, 31)), hrd, br, cv, ct, $urandom, cmis, $urandom);
    end
    rdy = 1'b1;
  endtask

  task automatic test_reset_mid();
    test_random(40);
    rst = 1'b0;
    #1;
    n_cmp++;
    if (rob_enable !== 1'b0 || rob_commit_index !== 5'd0 || rob_commit_rename !== 5'd0 ||
        rob_commit_value !== 32'd0 || jump_wrong !== 1'b0 || jump_target !== 32'd0 ||
        alloc_tag !== 5'd1 || rob_full !== 1'b0) begin
      n_bad++; $display("FAIL reset_mid got en %0b ren %0d val %h jw %0b tag %0d exp zeros/tag1",
                        rob_enable, rob_commit_rename, rob_commit_value, jump_wrong, alloc_tag);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    idle(2);
  endtask

`ifdef ROB_QUERY_EN
  task automatic test_query();
    apply_reset();
    for (int i = 0; i < 5; i++) alloc1(5'(i + 1), 1, 0);
    cdb1(5'd4, 32'h55, 0, 0);
    q1_tag = 5'd4; q2_tag = 5'd5;
    cdb_valid = 1'b1; cdb_tag = 5'd5; cdb_value = 32'h66;
    #1;
    n_cmp++;
    if (q1_ready !== 1'b1 || q1_value !== 32'h55 || q2_ready !== 1'b1 || q2_value !== 32'h66) begin
      n_bad++; $display("FAIL query got %0b/%h %0b/%h exp 1/55 1/66", q1_ready, q1_value, q2_ready, q2_value);
    end
    cdb1(5'd5, 32'h66, 0, 0);
    q1_tag = 5'd0; q2_tag = 5'd0;
  endtask
`endif

  initial begin
    test_reset();
    test_in_order();
    test_full_wrap();
    test_mispredict();
    test_store_and_ignored();
    test_rdy_low();
`ifdef ROB_QUERY_EN
    test_query();
`endif
    test_random(600);
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
